reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register and data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; register count = 2**ADDR_W (32).
REQ-003 SHALL use one clock and a synchronous, active-high reset; the clock and reset ports are named clk and rst.
REQ-004 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port we, input, 1, write enable.
REQ-007 SHALL have port ra1, input, ADDR_W, read address, port 1.
REQ-008 SHALL have port ra2, input, ADDR_W, read address, port 2.
REQ-009 SHALL have port wa, input, ADDR_W, write address.
REQ-010 SHALL have port wd, input, DATA_W, write data.
REQ-011 SHALL have port rd1, output, DATA_W, read data, port 1.
REQ-012 SHALL have port rd2, output, DATA_W, read data, port 2.

Function
REQ-013 SHALL hold 2**ADDR_W registers of DATA_W bits each.
REQ-014 SHALL write wd into register wa on a rising clk edge when we=1 and rst=0.
REQ-015 SHALL leave all registers unchanged on an edge where we=0.
REQ-016 SHALL treat register 0 as hardwired zero: writes to wa=0 are discarded, and reads of address 0 return 0.
REQ-017 SHALL make reads combinational: rd1 = reg[ra1] and rd2 = reg[ra2], with zero-cycle latency from an address change.
REQ-018 SHALL make both read ports fully independent; ra1=ra2 returns identical data on both ports.
REQ-019 SHALL make written data visible on the read ports immediately after the write edge (one-edge write latency).
REQ-020 SHALL, without the bypass feature, return the old register content when a read and a write hit the same address in one cycle, until the edge.
REQ-021 SHALL give rst priority over we on the same edge; the write is dropped.

Reset
REQ-022 SHALL clear every register to 0 on a rising edge with rst=1.
REQ-023 SHALL, during and immediately after reset, drive rd1 and rd2 to 0 for every address.
REQ-024 SHALL initialise no register contents other than by rst (contents are undefined before the first reset).

Configuration
REQ-025 SHALL support macro REG_FILE_BYPASS_EN: when defined, a read address equal to a nonzero wa with we=1 and rst=0 returns wd combinationally (write-through).
REQ-026 SHALL, without REG_FILE_BYPASS_EN, read only stored contents, as stated in REQ-020.
REQ-027 SHALL never bypass to address 0, regardless of REG_FILE_BYPASS_EN.

Structure
REQ-028 SHALL take DATA_W and ADDR_W defaults and the ZERO_REG index constant (0) from shared package reg_file_pkg.
REQ-029 SHALL implement each read port as sub-module reg_file_rd_port (address decode, zero-register masking, optional bypass mux), instantiated twice.
REQ-030 SHALL place the storage array and write logic in reg_file itself.

Verification
REQ-031 SHALL pass: rst=1 for one edge, then read addresses 0..31 on both ports -> all rd1/rd2 = 32'h0000_0000.
REQ-032 SHALL pass: we=1, wa=1, wd=32'hDEAD_BEEF for one edge, then we=0, ra1=1 -> rd1 = 32'hDEAD_BEEF.
REQ-033 SHALL pass: we=1, wa=0, wd=32'hFFFF_FFFF, then ra1=0, ra2=0 -> rd1 = rd2 = 0.
REQ-034 SHALL pass: write r5=32'h1234_5678 and r31=32'hCAFE_F00D, then ra1=5, ra2=31 -> rd1 = 32'h1234_5678, rd2 = 32'hCAFE_F00D; ra1=ra2=31 -> both 32'hCAFE_F00D.
REQ-035 SHALL pass: r3=32'h1, then we=1, wa=3, wd=32'h2, ra1=3, sampled before the edge -> rd1 = 32'h2 with REG_FILE_BYPASS_EN, 32'h1 without; 32'h2 after the edge in both cases.
REQ-036 SHALL pass: rst=1 and we=1, wa=7, wd=32'hAAAA_AAAA on the same edge, then ra1=7 -> rd1 = 0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants for the register file: default geometry and the
// index of the hardwired-zero register.
// Optional feature macro: REG_FILE_BYPASS_EN (write-through on reads).
package reg_file_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int ZERO_REG   = 0;

    // True when addr selects the hardwired-zero register.
    function automatic logic is_zero_reg(input logic [ADDR_W_DEF-1:0] addr);
        return addr == ADDR_W_DEF'(ZERO_REG);
    endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port of the register file: address decode,
// zero-register masking and, when REG_FILE_BYPASS_EN is defined, a
// write-through mux that forwards the in-flight write data.
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra,
    input  logic [DATA_W-1:0] regs [0:(1<<ADDR_W)-1],
`ifdef REG_FILE_BYPASS_EN
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
`endif
    output logic [DATA_W-1:0] rd
);

    // Select stored data, optionally forward the pending write, then force
    // zero for the zero register and while reset is asserted (storage may
    // still be undefined before the first reset edge).
    always_comb begin
        rd = regs[ra];
`ifdef REG_FILE_BYPASS_EN
        // Address 0 is never forwarded: the zero mask below overrides it.
        if (we && (wa == ra)) begin
            rd = wd;
        end
`endif
        if (rst || (ra == ADDR_W'(ZERO_REG))) begin
            rd = '0;
        end
    end

endmodule

// File: rtl/reg_file.sv
// Two-read, one-write register file with a hardwired-zero register 0.
// Storage and write logic live here; each read port is a reg_file_rd_port.
// Optional feature macro: REG_FILE_BYPASS_EN (same-cycle write-through).
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // Reset clears every entry and wins over a same-edge write; writes to
    // the zero register are dropped so entry 0 stays zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (wa != ADDR_W'(ZERO_REG))) begin
            mem[wa] <= wd;
        end
    end

    reg_file_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rd_port1 (
        .rst  (rst),
        .ra   (ra1),
        .regs (mem),
`ifdef REG_FILE_BYPASS_EN
        .we   (we),
        .wa   (wa),
        .wd   (wd),
`endif
        .rd   (rd1)
    );

    reg_file_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rd_port2 (
        .rst  (rst),
        .ra   (ra2),
        .regs (mem),
`ifdef REG_FILE_BYPASS_EN
        .we   (we),
        .wa   (wa),
        .wd   (wd),
`endif
        .rd   (rd2)
    );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus a randomized
// run compared against an array-based reference model.
module tb_reg_file;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk;
    logic          rst;
    logic          we;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;

    logic [DW-1:0] model [NR];
    int total;
    int bad;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    reg_file dut (
        .clk (clk),
        .rst (rst),
        .we  (we),
        .ra1 (ra1),
        .ra2 (ra2),
        .wa  (wa),
        .wd  (wd),
        .rd1 (rd1),
        .rd2 (rd2)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected read value for address a given current model and write inputs.
    function automatic logic [DW-1:0] expect_rd(input int a, input bit w,
                                                input int waddr, input logic [DW-1:0] wdata);
        if (a == 0) return '0;
        if (BYPASS && w && (waddr == a)) return wdata;
        return model[a];
    endfunction

    // Driver: one write edge, model updated at the edge.
    task automatic write_reg(input int a, input logic [DW-1:0] d);
        @(negedge clk);
        we = 1'b1;
        wa = AW'(a);
        wd = d;
        @(posedge clk);
        if (a != 0) model[a] = d;
        #1;
        we = 1'b0;
    endtask

    task automatic test_reset();
        // Outputs must read zero while reset is held, even before any edge.
        @(negedge clk);
        rst = 1'b1;
        we  = 1'b0;
        ra1 = 5'd9;
        ra2 = 5'd22;
        #1;
        total++;
        if (rd1 !== '0 || rd2 !== '0) begin
            bad++;
            $display("FAIL during_reset rd1=%h rd2=%h want 0", rd1, rd2);
        end
        @(posedge clk);
        for (int i = 0; i < NR; i++) model[i] = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < NR; a++) begin
            ra1 = AW'(a);
            ra2 = AW'(NR - 1 - a);
            #1;
            total++;
            if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
                bad++;
                $display("FAIL reset_clear a=%0d rd1=%h rd2=%h want 0", a, rd1, rd2);
            end
        end
    endtask

    task automatic test_write_read();
        write_reg(1, 32'hDEAD_BEEF);
        ra1 = 5'd1;
        #1;
        total++;
        if (rd1 !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL write_read rd1=%h want DEADBEEF", rd1);
        end
    endtask

    task automatic test_zero_reg();
        write_reg(0, 32'hFFFF_FFFF);
        ra1 = 5'd0;
        ra2 = 5'd0;
        #1;
        total++;
        if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
            bad++;
            $display("FAIL zero_reg rd1=%h rd2=%h want 0", rd1, rd2);
        end
        // Bypass must never reach address 0.
        @(negedge clk);
        we = 1'b1;
        wa = 5'd0;
        wd = 32'h5555_5555;
        #1;
        total++;
        if (rd1 !== 32'h0) begin
            bad++;
            $display("FAIL zero_bypass rd1=%h want 0", rd1);
        end
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic test_two_ports();
        write_reg(5, 32'h1234_5678);
        write_reg(31, 32'hCAFE_F00D);
        ra1 = 5'd5;
        ra2 = 5'd31;
        #1;
        total++;
        if (rd1 !== 32'h1234_5678 || rd2 !== 32'hCAFE_F00D) begin
            bad++;
            $display("FAIL two_ports rd1=%h rd2=%h want 12345678 CAFEF00D", rd1, rd2);
        end
        ra1 = 5'd31;
        #1;
        total++;
        if (rd1 !== 32'hCAFE_F00D || rd2 !== 32'hCAFE_F00D) begin
            bad++;
            $display("FAIL same_addr rd1=%h rd2=%h want CAFEF00D", rd1, rd2);
        end
    endtask

    task automatic test_same_cycle();
        logic [DW-1:0] want;
        write_reg(3, 32'h1);
        @(negedge clk);
        we  = 1'b1;
        wa  = 5'd3;
        wd  = 32'h2;
        ra1 = 5'd3;
        #1;
        want = BYPASS ? 32'h2 : 32'h1;
        total++;
        if (rd1 !== want) begin
            bad++;
            $display("FAIL pre_edge rd1=%h want %h", rd1, want);
        end
        @(posedge clk);
        model[3] = 32'h2;
        #1;
        we = 1'b0;
        #1;
        total++;
        if (rd1 !== 32'h2) begin
            bad++;
            $display("FAIL post_edge rd1=%h want 2", rd1);
        end
    endtask

    task automatic test_reset_priority();
        write_reg(7, 32'h0BAD_0007);
        @(negedge clk);
        rst = 1'b1;
        we  = 1'b1;
        wa  = 5'd7;
        wd  = 32'hAAAA_AAAA;
        @(posedge clk);
        for (int i = 0; i < NR; i++) model[i] = '0;
        #1;
        rst = 1'b0;
        we  = 1'b0;
        ra1 = 5'd7;
        ra2 = 5'd1;
        #1;
        total++;
        if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
            bad++;
            $display("FAIL reset_priority rd1=%h rd2=%h want 0", rd1, rd2);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
        int a1;
        int a2;
        int aw;
        bit w;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            w  = ($urandom_range(0, 3) != 0);
            aw = $urandom_range(0, NR - 1);
            a1 = ($urandom_range(0, 3) == 0) ? aw : $urandom_range(0, NR - 1);
            a2 = ($urandom_range(0, 3) == 0) ? aw : $urandom_range(0, NR - 1);
            we  = w;
            wa  = AW'(aw);
            wd  = $urandom;
            ra1 = AW'(a1);
            ra2 = AW'(a2);
            #1;
            e1 = expect_rd(a1, w, aw, wd);
            e2 = expect_rd(a2, w, aw, wd);
            total++;
            if (rd1 !== e1 || rd2 !== e2) begin
                bad++;
                $display("FAIL random n=%0d ra1=%0d ra2=%0d rd1=%h rd2=%h want %h %h",
                         n, a1, a2, rd1, rd2, e1, e2);
            end
            @(posedge clk);
            if (w && aw != 0) model[aw] = wd;
        end
        #1;
        we = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i < NR; i++) write_reg(i, DW'(32'h1000_0000 + i * 3));
        for (int a = 0; a < NR; a++) begin
            ra1 = AW'(a);
            ra2 = AW'(NR - 1 - a);
            #1;
            total++;
            if (rd1 !== expect_rd(a, 1'b0, 0, '0) ||
                rd2 !== expect_rd(NR - 1 - a, 1'b0, 0, '0)) begin
                bad++;
                $display("FAIL back_to_back a=%0d rd1=%h rd2=%h", a, rd1, rd2);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b0;
        we  = 1'b0;
        ra1 = '0;
        ra2 = '0;
        wa  = '0;
        wd  = '0;
        test_reset();
        test_write_read();
        test_zero_reg();
        test_two_ports();
        test_same_cycle();
        test_reset_priority();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
